// File: rtl/interp_halfpel_engine.sv
// Streaming HEVC 8-tap luma half-sample interpolator: one row of LANES positions per beat,
// 3-stage stallable pipeline, start/done row sequencer. Define INTERP_QPEL_EN to add quarter-sample outputs.
module interp_halfpel_engine #(
    parameter int DATAWIDTH = 8,
    parameter int LANES     = 8,
    parameter int ROW_W     = 6
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ROW_W-1:0]               num_rows,
    output logic                           busy,
    output logic                           done,
    output logic [ROW_W-1:0]               row_cnt,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [(LANES+7)*DATAWIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*DATAWIDTH-1:0]     out_half,
    output logic                           out_last
`ifdef INTERP_QPEL_EN
    ,
    output logic [LANES*DATAWIDTH-1:0]     out_qa,
    output logic [LANES*DATAWIDTH-1:0]     out_qc
`endif
);
    // state    | meaning
    // ST_IDLE  | waiting for start
    // ST_RUN   | accepting input rows until num_rows have been taken
    // ST_DRAIN | all rows accepted, waiting for the last row to leave
    // ST_DONE  | one-cycle done pulse

    localparam int SW    = DATAWIDTH + 8;
    localparam int WIN_W = (LANES + 7) * DATAWIDTH;
    localparam int TAP_W = 8 * DATAWIDTH;

    typedef logic signed [SW-1:0] sum_t;

    localparam sum_t ROUND_K = sum_t'(32);
    localparam sum_t MAX_V   = sum_t'((1 << DATAWIDTH) - 1);

    // Packed coefficient tables list tap 7 first, tap 0 last.
    localparam logic [7:0][7:0] HALF_COEF =
        {-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
`ifdef INTERP_QPEL_EN
    localparam logic [7:0][7:0] QA_COEF =
        {8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};
    localparam logic [7:0][7:0] QC_COEF =
        {-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
`endif

    function automatic sum_t fir(input logic [TAP_W-1:0] win, input logic [7:0][7:0] coef);
        sum_t acc;
        sum_t px;
        sum_t cf;
        acc = '0;
        for (int t = 0; t < 8; t++) begin
            px  = {8'd0, win[t*DATAWIDTH +: DATAWIDTH]};
            cf  = {{DATAWIDTH{coef[t][7]}}, coef[t]};
            acc = acc + px * cf;
        end
        return acc;
    endfunction

    function automatic logic [DATAWIDTH-1:0] round_clip(input sum_t s);
        sum_t r;
        logic [DATAWIDTH-1:0] res;
        r = (s + ROUND_K) >>> 6;
        if (r[SW-1])
            res = '0;
        else if (r > MAX_V)
            res = '1;
        else
            res = r[DATAWIDTH-1:0];
        return res;
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t            state;
    logic [ROW_W-1:0]  rows_q;
    logic              v1, v2, l1, l2;
    logic [WIN_W-1:0]  s1_data;
    sum_t              half_sum [LANES];
    sum_t              s2_half  [LANES];
`ifdef INTERP_QPEL_EN
    sum_t              qa_sum [LANES];
    sum_t              qc_sum [LANES];
    sum_t              s2_qa  [LANES];
    sum_t              s2_qc  [LANES];
`endif
    logic              en1, en2, en3, accept, last_in, out_fire;

    assign en3      = !out_valid | out_ready;
    assign en2      = !v2 | en3;
    assign en1      = !v1 | en2;
    assign in_ready = (state == ST_RUN) & en1;
    assign accept   = in_valid & in_ready;
    assign last_in  = (row_cnt == rows_q - ROW_W'(1));
    assign out_fire = out_valid & out_ready;
    assign busy     = (state == ST_RUN) | (state == ST_DRAIN);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            rows_q  <= '0;
            row_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    rows_q  <= num_rows;
                    row_cnt <= '0;
                    state   <= (num_rows == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: if (accept) begin
                    row_cnt <= row_cnt + ROW_W'(1);
                    if (row_cnt + ROW_W'(1) == rows_q)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: if (out_fire && out_last)
                    state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            half_sum[i] = fir(s1_data[i*DATAWIDTH +: TAP_W], HALF_COEF);
`ifdef INTERP_QPEL_EN
            qa_sum[i]   = fir(s1_data[i*DATAWIDTH +: TAP_W], QA_COEF);
            qc_sum[i]   = fir(s1_data[i*DATAWIDTH +: TAP_W], QC_COEF);
`endif
        end
    end

    // Each stage loads only when its successor can take its current content.
    always_ff @(posedge clock) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            l1        <= 1'b0;
            l2        <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_half  <= '0;
            for (int i = 0; i < LANES; i++) begin
                s2_half[i] <= '0;
`ifdef INTERP_QPEL_EN
                s2_qa[i]   <= '0;
                s2_qc[i]   <= '0;
`endif
            end
`ifdef INTERP_QPEL_EN
            out_qa    <= '0;
            out_qc    <= '0;
`endif
        end else begin
            if (en1) begin
                v1 <= accept;
                l1 <= accept & last_in;
                if (accept)
                    s1_data <= in_data;
            end
            if (en2) begin
                v2 <= v1;
                l2 <= l1;
                for (int i = 0; i < LANES; i++) begin
                    s2_half[i] <= half_sum[i];
`ifdef INTERP_QPEL_EN
                    s2_qa[i]   <= qa_sum[i];
                    s2_qc[i]   <= qc_sum[i];
`endif
                end
            end
            if (en3) begin
                out_valid <= v2;
                out_last  <= l2;
                for (int i = 0; i < LANES; i++) begin
                    out_half[i*DATAWIDTH +: DATAWIDTH] <= round_clip(s2_half[i]);
`ifdef INTERP_QPEL_EN
                    out_qa[i*DATAWIDTH +: DATAWIDTH]   <= round_clip(s2_qa[i]);
                    out_qc[i*DATAWIDTH +: DATAWIDTH]   <= round_clip(s2_qc[i]);
`endif
                end
            end
        end
    end
endmodule
